// File: rtl/flappy_pkg.sv
// Shared types and helpers for the bird/pipe playfield blocks.
package flappy_pkg;

    localparam int unsigned ROWS = 16;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef logic [ROWS-1:0] column_t;

    typedef enum logic [1:0] {IDLE, SPACE, PIPE, FROZEN} pipe_state_t;

    // Keep the gap fully on screen with at least one wall row above and below it.
    function automatic logic [3:0] clamp_gap(input logic [3:0] raw, input int unsigned gap_h);
        logic [3:0] hi;
        hi = 4'(15 - gap_h);
        if (raw == 4'd0) begin
            return 4'd1;
        end
        if (raw > hi) begin
            return hi;
        end
        return raw;
    endfunction

    function automatic column_t wall_column(input logic [3:0] gap_lo, input int unsigned gap_h);
        column_t gap_mask;
        gap_mask = ((column_t'(1) << gap_h) - column_t'(1)) << gap_lo;
        return ~gap_mask;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR; a zero seed is replaced by 1 so the register never locks up.
module lfsr16
    import flappy_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [15:0] seed,
    output logic [15:0] state
);

    logic [15:0] state_d;
    logic [15:0] state_q;

    always_comb begin
        state_d = state_q;
        if (en) begin
            state_d = {1'b0, state_q[15:1]} ^ (state_q[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= (seed == 16'h0000) ? 16'h0001 : seed;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/pipe_gen.sv
// Scrolling pipe column generator at the bird column, with a one-cycle step strobe.
// Define SPEEDUP_EN to shorten the scroll period after every completed pipe.
module pipe_gen
    import flappy_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 25000000,
    parameter int unsigned SPACING    = 6,
    parameter int unsigned PIPE_WIDTH = 2,
    parameter int unsigned GAP_H      = 4,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       gameover,
    output column_t    pipe,
    output logic       pipe_step,
    output logic [7:0] pipes_passed
);

    localparam int unsigned TW      = $clog2(TICK_DIV);
    localparam int unsigned COL_MAX = (SPACING > PIPE_WIDTH) ? SPACING : PIPE_WIDTH;
    localparam int unsigned CW      = (COL_MAX > 1) ? $clog2(COL_MAX) : 1;

    localparam logic [CW-1:0] SPACE_LAST     = CW'(SPACING - 1);
    localparam logic [CW-1:0] PIPE_LAST      = CW'(PIPE_WIDTH - 1);
    localparam logic [TW-1:0] PERIOD_M1_INIT = TW'(TICK_DIV - 1);

    pipe_state_t   state_d, state_q;
    logic [TW-1:0] tick_d, tick_q;
    logic [CW-1:0] col_d, col_q;
    logic [3:0]    gap_d, gap_q;
    column_t       pipe_d, pipe_q;
    logic          step_d, step_q;
    logic [7:0]    passed_d, passed_q;
    logic [15:0]   lfsr_state;
    logic          lfsr_en;
    logic          unused_lfsr;

`ifdef SPEEDUP_EN
    localparam int unsigned SPEED_DEC      = TICK_DIV / 16;
    localparam int unsigned SPEED_FLOOR_M1 = TICK_DIV / 4 - 1;
    logic [TW-1:0] period_m1_d, period_m1_q;
`else
    logic [TW-1:0] period_m1_q;
    assign period_m1_q = PERIOD_M1_INIT;
`endif

    assign lfsr_en     = run && (state_q != FROZEN);
    assign unused_lfsr = ^lfsr_state[15:4];

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (lfsr_en),
        .seed  (SEED),
        .state (lfsr_state)
    );

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        col_d    = col_q;
        gap_d    = gap_q;
        pipe_d   = pipe_q;
        step_d   = 1'b0;
        passed_d = passed_q;
`ifdef SPEEDUP_EN
        period_m1_d = period_m1_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = SPACE;
                    tick_d  = '0;
                    col_d   = '0;
                end
            end
            SPACE, PIPE: begin
                // A freeze takes priority over a step due on the same edge.
                if (gameover) begin
                    state_d = FROZEN;
                end else if (run) begin
                    if (tick_q == period_m1_q) begin
                        tick_d = '0;
                        step_d = 1'b1;
                        col_d  = col_q + 1'b1;
                        if (state_q == SPACE) begin
                            pipe_d = '0;
                            if (col_q == SPACE_LAST) begin
                                state_d = PIPE;
                                col_d   = '0;
                                gap_d   = clamp_gap(lfsr_state[3:0], GAP_H);
                            end
                        end else begin
                            pipe_d = wall_column(gap_q, GAP_H);
                            if (col_q == PIPE_LAST) begin
                                state_d = SPACE;
                                col_d   = '0;
                                if (passed_q != 8'hFF) begin
                                    passed_d = passed_q + 8'd1;
                                end
`ifdef SPEEDUP_EN
                                if (32'(period_m1_q) >= SPEED_FLOOR_M1 + SPEED_DEC) begin
                                    period_m1_d = period_m1_q - TW'(SPEED_DEC);
                                end else begin
                                    period_m1_d = TW'(SPEED_FLOOR_M1);
                                end
`endif
                            end
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            FROZEN: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            tick_q   <= '0;
            col_q    <= '0;
            gap_q    <= '0;
            pipe_q   <= '0;
            step_q   <= 1'b0;
            passed_q <= '0;
`ifdef SPEEDUP_EN
            period_m1_q <= PERIOD_M1_INIT;
`endif
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            col_q    <= col_d;
            gap_q    <= gap_d;
            pipe_q   <= pipe_d;
            step_q   <= step_d;
            passed_q <= passed_d;
`ifdef SPEEDUP_EN
            period_m1_q <= period_m1_d;
`endif
        end
    end

    assign pipe         = pipe_q;
    assign pipe_step    = step_q;
    assign pipes_passed = passed_q;

endmodule

// File: tb/tb_pipe_gen.sv
// Bench for pipe_gen: vector table, hand sequences, and random stimulus against a reference model.
module tb_pipe_gen;

`ifdef SPEEDUP_EN
    localparam int TD = 64;
`else
    localparam int TD = 4;
`endif
    localparam int SP = 3;
    localparam int PW = 2;
    localparam int GH = 4;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        gameover = 1'b0;
    logic [15:0] pipe;
    logic        pipe_step;
    logic [7:0]  pipes_passed;

    always #5 clk = ~clk;

    pipe_gen #(
        .TICK_DIV   (TD),
        .SPACING    (SP),
        .PIPE_WIDTH (PW),
        .GAP_H      (GH),
        .SEED       (SEED)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .gameover     (gameover),
        .pipe         (pipe),
        .pipe_step    (pipe_step),
        .pipes_passed (pipes_passed)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Reference model: pipe position within one SPACE+PIPE cycle, tick count, LFSR value.
    bit          m_started, m_frozen, m_step;
    int          m_tick, m_pos, m_period, m_passed, m_gap;
    logic [15:0] m_lfsr, m_pipe;

    function automatic logic [15:0] ref_lfsr_next(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic int ref_clamp(input int raw);
        if (raw < 1) return 1;
        if (raw > 15 - GH) return 15 - GH;
        return raw;
    endfunction

    function automatic logic [15:0] ref_wall(input int lo);
        logic [15:0] c;
        for (int r = 0; r < 16; r++) c[r] = (r < lo || r >= lo + GH);
        return c;
    endfunction

    function automatic int lowest_zero(input logic [15:0] c);
        for (int r = 0; r < 16; r++) if (!c[r]) return r;
        return -1;
    endfunction

    function automatic int exp_period(input int k);
`ifdef SPEEDUP_EN
        int p;
        p = TD - (TD / 16) * ((k - 1) / (SP + PW));
        return (p < TD / 4) ? TD / 4 : p;
`else
        return TD + 0 * k;
`endif
    endfunction

    task automatic model_edge(input bit r, input bit g, input bit rs);
        logic [15:0] pre;
        if (rs) begin
            m_started = 0; m_frozen = 0; m_step = 0; m_tick = 0; m_pos = 0;
            m_pipe = '0; m_passed = 0; m_lfsr = SEED; m_gap = 0; m_period = TD;
            return;
        end
        pre = m_lfsr;
        m_step = 0;
        if (r && !m_frozen) m_lfsr = ref_lfsr_next(m_lfsr);
        if (!m_started) begin
            if (r) begin
                m_started = 1; m_tick = 0; m_pos = 0;
            end
        end else if (m_frozen) begin
        end else if (g) begin
            m_frozen = 1;
        end else if (r) begin
            if (m_tick == m_period - 1) begin
                m_tick = 0;
                m_step = 1;
                if (m_pos < SP) begin
                    m_pipe = '0;
                    if (m_pos == SP - 1) m_gap = ref_clamp(int'(pre[3:0]));
                end else begin
                    m_pipe = ref_wall(m_gap);
                end
                if (m_pos == SP + PW - 1) begin
                    if (m_passed < 255) m_passed++;
`ifdef SPEEDUP_EN
                    m_period = (m_period - TD / 16 < TD / 4) ? TD / 4 : m_period - TD / 16;
`endif
                end
                m_pos = (m_pos + 1) % (SP + PW);
            end else begin
                m_tick++;
            end
        end
    endtask

    task automatic cyc(input bit r, input bit g, input bit rs);
        run = r;
        gameover = g;
        reset = rs;
        model_edge(r, g, rs);
        @(posedge clk);
        #1;
        chk("model_pipe", pipe, m_pipe);
        chk("model_step", pipe_step, m_step);
        chk("model_passed", pipes_passed, m_passed);
    endtask

    task automatic check_shape(input string name);
        int lo;
        lo = lowest_zero(pipe);
        chk({name, "_popcount"}, $countones(pipe), 16 - GH);
        chk({name, "_edges"}, {pipe[15], pipe[0]}, 2'b11);
        chk({name, "_contig"}, pipe, ref_wall(lo));
        chk({name, "_range"}, (lo >= 1 && lo <= 15 - GH), 1);
    endtask

    task automatic run_strobes(input int n);
        int seen, g;
        seen = 0;
        g = 0;
        while (seen < n && g < n * 4 * TD) begin
            cyc(1, 0, 0);
            g++;
            if (pipe_step) seen++;
        end
        chk("strobe_wait", seen, n);
    endtask

    typedef struct {
        int n;
        bit run;
        bit stp;
        bit nz;
        int psd;
        int cap;
    } vec_t;

    function automatic vec_t mk(input int n, input int r, input int s, input int z, input int p,
                                input int c);
        vec_t v;
        v.n = n; v.run = bit'(r); v.stp = bit'(s); v.nz = bit'(z); v.psd = p; v.cap = c;
        return v;
    endfunction

    initial begin
        vec_t        tbl[$];
        logic [15:0] cap, held, a, b;
        int          nstr, cnt, lo, ng, guard;
        bit          r, g, rs;

        // Reset state
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        chk("rst_pipe", pipe, 0);
        chk("rst_step", pipe_step, 0);
        chk("rst_passed", pipes_passed, 0);
        cyc(0, 0, 0);
        chk("idle_step", pipe_step, 0);

`ifndef SPEEDUP_EN
        // {cycles, run, step at last, pipe nonzero, passed, 1=capture 2=must equal capture}
        tbl.push_back(mk(1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(3, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(4, 1, 1, 0, 0, 0));
        tbl.push_back(mk(4, 1, 1, 0, 0, 0));
        tbl.push_back(mk(3, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 1, 0, 1));
        tbl.push_back(mk(4, 1, 1, 1, 1, 2));
        tbl.push_back(mk(4, 1, 1, 0, 1, 0));
        tbl.push_back(mk(4, 1, 1, 0, 1, 0));
        tbl.push_back(mk(4, 1, 1, 0, 1, 0));
        tbl.push_back(mk(4, 1, 1, 1, 1, 1));
        tbl.push_back(mk(2, 1, 0, 1, 1, 0));
        tbl.push_back(mk(10, 0, 0, 1, 1, 2));
        tbl.push_back(mk(1, 1, 0, 1, 1, 0));
        tbl.push_back(mk(1, 1, 1, 1, 2, 2));
        cap = '0;
        for (int i = 0; i < tbl.size(); i++) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                cyc(tbl[i].run, 0, 0);
                if (k < tbl[i].n - 1) chk("tbl_quiet", pipe_step, 0);
            end
            chk("tbl_step", pipe_step, tbl[i].stp);
            chk("tbl_nz", pipe != 16'h0, tbl[i].nz);
            chk("tbl_passed", pipes_passed, tbl[i].psd);
            if (tbl[i].nz) check_shape("tbl_shape");
            if (tbl[i].cap == 1) cap = pipe;
            else if (tbl[i].cap == 2) chk("tbl_hold", pipe, cap);
        end
`endif

        // Gameover exactly on a due step
        cyc(0, 0, 1);
        cyc(1, 0, 0);
        repeat (4 * TD) cyc(1, 0, 0);
        chk("go_pre_step", pipe_step, 1);
        held = pipe;
        chk("go_pre_nz", held != 16'h0, 1);
        repeat (TD - 1) cyc(1, 0, 0);
        cyc(1, 1, 0);
        chk("go_step", pipe_step, 0);
        chk("go_pipe", pipe, held);
        chk("go_passed", pipes_passed, 0);
        nstr = 0;
        repeat (100) begin
            cyc(1, 0, 0);
            if (pipe_step) nstr++;
        end
        chk("go_strobes", nstr, 0);
        chk("go_hold", pipe, held);
        cyc(1, 0, 1);
        chk("go_rst_pipe", pipe, 0);
        chk("go_rst_passed", pipes_passed, 0);
        chk("go_rst_step", pipe_step, 0);
        // Back in IDLE: gameover ignored, first strobe TD cycles after run
        repeat (3) cyc(0, 1, 0);
        chk("idle_go_step", pipe_step, 0);
        cyc(1, 0, 0);
        cnt = 0;
        do begin
            cyc(1, 0, 0);
            cnt++;
        end while (!pipe_step && cnt < 4 * TD);
        chk("idle_first", cnt, TD);

        // Reset mid-PIPE restarts the gap sequence
        cyc(0, 0, 1);
        cyc(1, 0, 0);
        run_strobes(4);
        a = pipe;
        run_strobes(5);
        b = pipe;
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        cyc(1, 0, 1);
        chk("midrst_pipe", pipe, 0);
        chk("midrst_step", pipe_step, 0);
        cyc(1, 0, 0);
        run_strobes(4);
        chk("midrst_gap1", pipe, a);
        run_strobes(5);
        chk("midrst_gap2", pipe, b);

        // Strobe intervals
        cyc(0, 0, 1);
        cyc(1, 0, 0);
`ifdef SPEEDUP_EN
        for (int k = 1; k <= 70; k++) begin
`else
        for (int k = 1; k <= 12; k++) begin
`endif
            cnt = 0;
            do begin
                cyc(1, 0, 0);
                cnt++;
            end while (!pipe_step && cnt < 2 * TD);
            chk("interval", cnt, exp_period(k));
        end

        // Gap positions over 50 pipes
        cyc(0, 0, 1);
        ng = 0;
        guard = 0;
        while (m_passed < 50 && guard < 60 * (SP + PW) * TD) begin
            cyc(1, 0, 0);
            guard++;
            if (m_step && m_pos == SP + 1) begin
                lo = lowest_zero(pipe);
                chk("gap_lo", lo, m_gap);
                chk("gap_range", (lo >= 1 && lo <= 15 - GH), 1);
                ng++;
            end
        end
        chk("gap_passed", pipes_passed, 50);
        chk("gap_count", ng, 50);

        // Random run/gameover/reset against the model
        repeat (3000) begin
            r = ($urandom_range(0, 7) != 0);
            g = ($urandom_range(0, 599) == 0);
            rs = ($urandom_range(0, 399) == 0);
            cyc(r, g, rs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
